sumador_64_bits_segmentado: RTL and testbench

SUMADOR_64_BITS_SEGMENTADO -- requirements
Module: sumador_64_bits_segmentado

---
 rtl/sumador_64_bits_segmentado.sv | 127 ++++++++++++
 tb/tb_sumador_64_bits_segmentado.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_64_bits_segmentado.sv
// Two-stage valid/ready pipelined 64-bit adder built from two 32-bit adders.
// The low half is added in stage 1; the high half uses the registered low carry in stage 2.

module sumador_32_bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    assign sum   = total[31:0];
    assign cout  = total[32];
endmodule

module sumador_64_bits_segmentado (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum,
    output logic        cout
);
    logic        s1_valid_reg, s1_valid_next;
    logic [31:0] s1_sum_lo_reg;
    logic        s1_carry_reg;
    logic [31:0] s1_a_hi_reg;
    logic [31:0] s1_b_hi_reg;

    logic        s2_valid_reg, s2_valid_next;
    logic [63:0] s2_sum_reg;
    logic        s2_cout_reg;

    logic [31:0] lo_sum;
    logic        lo_cout;
    logic [31:0] hi_sum;
    logic        hi_cout;

    logic        accept;
    logic        pop;
    logic        advance2;
    logic        load2;

    sumador_32_bits u_lo (
        .a    (a[31:0]),
        .b    (b[31:0]),
        .cin  (cin),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    sumador_32_bits u_hi (
        .a    (s1_a_hi_reg),
        .b    (s1_b_hi_reg),
        .cin  (s1_carry_reg),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // Stage 2 can take a new entry if it is empty or its entry leaves this cycle.
    assign pop      = s2_valid_reg & out_ready;
    assign advance2 = ~s2_valid_reg | out_ready;
    assign load2    = s1_valid_reg & advance2;
    assign in_ready = ~rst & (~s1_valid_reg | load2);
    assign accept   = in_valid & in_ready;

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s2_valid_next = s2_valid_reg;
        if (accept) begin
            s1_valid_next = 1'b1;
        end else if (load2) begin
            s1_valid_next = 1'b0;
        end
        if (load2) begin
            s2_valid_next = 1'b1;
        end else if (pop) begin
            s2_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
        end
    end

    // Data registers only move when an entry actually enters the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sum_lo_reg <= '0;
            s1_carry_reg  <= 1'b0;
            s1_a_hi_reg   <= '0;
            s1_b_hi_reg   <= '0;
        end else if (accept) begin
            s1_sum_lo_reg <= lo_sum;
            s1_carry_reg  <= lo_cout;
            s1_a_hi_reg   <= a[63:32];
            s1_b_hi_reg   <= b[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sum_reg  <= '0;
            s2_cout_reg <= 1'b0;
        end else if (load2) begin
            s2_sum_reg  <= {hi_sum, s1_sum_lo_reg};
            s2_cout_reg <= hi_cout;
        end
    end

    assign out_valid = s2_valid_reg;
    assign sum       = s2_sum_reg;
    assign cout      = s2_cout_reg;
endmodule

// File: tb/tb_sumador_64_bits_segmentado.sv
// Scoreboard bench for the pipelined 64-bit adder: directed latency, wrap,
// streaming, backpressure and reset cases followed by a long random run.

module tb_sumador_64_bits_segmentado;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;

    int n_checks = 0;
    int n_fail   = 0;
    int out_cnt  = 0;
    int rst_events = 0;

    logic [64:0] sb_q[$];

    logic        hold_prev = 1'b0;
    logic [64:0] held;
    int          rst_snap = 0;

    sumador_64_bits_segmentado dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge rst) rst_events++;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {64'b0, c};
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return {32'h0, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Handshakes are observed at the falling edge; they complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (hold_prev && rst_snap == rst_events) begin
                check("hold_valid", 65'(out_valid), 65'(1));
                check("hold_data", {cout, sum}, held);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 65'(out_valid), 65'(0));
                end else begin
                    check("result", {cout, sum}, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_add(a, b, cin));
            end
        end
        hold_prev = !rst && out_valid && !out_ready;
        held      = {cout, sum};
        rst_snap  = rst_events;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c);
        bit done = 0;
        step();
        a = x; b = y; cin = c; in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) check("send_timeout", 65'(in_ready), 65'(1));
    endtask

    task automatic drain();
        bit done = 0;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) done = 1;
            else step();
        end
        check("drain_empty", 65'(sb_q.size()), 65'(0));
        check("drain_out_valid", 65'(out_valid), 65'(0));
    endtask

    initial begin
        bit accepted;
        int cnt0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 65'(out_valid), 65'(0));
        check("rst_in_ready", 65'(in_ready), 65'(0));
        check("rst_sum", {cout, sum}, 65'(0));

        step();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 65'(in_ready), 65'(1));

        // Basic add with exact latency
        step();
        out_ready = 1'b1;
        a = 64'h0000_0001_FFFF_FFFF; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("basic_in_ready", 65'(in_ready), 65'(1));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat1_out_valid", 65'(out_valid), 65'(0));
        step();
        @(negedge clk);
        check("lat2_out_valid", 65'(out_valid), 65'(1));
        check("basic_sum", {cout, sum}, 65'h0_0000_0002_0000_0000);
        drain();

        // Wrap-around cases
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap1_sum", {cout, sum}, {1'b1, 64'h0});
        step();
        @(negedge clk);
        check("wrap2_sum", {cout, sum}, {1'b1, 64'h0});
        drain();

        // Back-to-back streaming
        for (int i = 0; i <= 10; i++) begin
            step();
            if (i < 8) begin
                a = rand64(); b = rand64(); cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) check("b2b_in_ready", 65'(in_ready), 65'(1));
            check("b2b_out_valid", 65'(out_valid), 65'(i >= 2 && i <= 9));
        end
        drain();

        // Backpressure: two entries fit, then in_ready drops
        cnt0 = out_cnt;
        accepted = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            out_ready = 1'b0;
            if (accepted) begin
                a = rand64(); b = rand64(); cin = 1'($urandom_range(0, 1));
            end
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_in_ready", 65'(in_ready), 65'(i < 2));
            if (i >= 2) check("bp_out_valid", 65'(out_valid), 65'(1));
            accepted = in_ready;
        end
        check("bp_accepted", 65'(sb_q.size()), 65'(2));
        drain();
        check("bp_drained", 65'(out_cnt - cnt0), 65'(2));

        // Reset with both stages full
        for (int i = 0; i < 2; i++) begin
            step();
            out_ready = 1'b0;
            a = rand64(); b = rand64(); cin = 1'b1; in_valid = 1'b1;
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", 65'(in_ready), 65'(0));
        check("full_out_valid", 65'(out_valid), 65'(1));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 65'(out_valid), 65'(0));
        check("midrst_sum", {cout, sum}, 65'(0));
        check("midrst_in_ready", 65'(in_ready), 65'(0));
        @(negedge clk);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_out", 65'(out_valid), 65'(0));
            check("post_rst_in_ready", 65'(in_ready), 65'(1));
            step();
        end
        check("post_rst_sb_empty", 65'(sb_q.size()), 65'(0));

        // Random traffic
        accepted = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = rand64(); b = rand64(); cin = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            accepted = in_valid && in_ready;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
